// File: rtl/nibble_serial_adder.sv
// Serial adder: streams W-bit operands one nibble per cycle through an external
// 4-bit ripple-carry adder and assembles the sum plus final carry-out.
module nibble_serial_adder #(
  parameter int NIBBLES = 4
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 start,
  input  logic [4*NIBBLES-1:0] a_in,
  input  logic [4*NIBBLES-1:0] b_in,
  input  logic                 cin_in,
  output logic [3:0]           rca_a,
  output logic [3:0]           rca_b,
  output logic                 rca_cin,
  input  logic [3:0]           rca_sum,
  input  logic                 rca_cout,
  output logic                 busy,
  output logic                 done,
  output logic [4*NIBBLES-1:0] result,
  output logic                 cout
);

  localparam int W  = 4 * NIBBLES;
  localparam int IW = (NIBBLES > 1) ? $clog2(NIBBLES) : 1;
  localparam logic [IW-1:0] LAST_IDX = IW'(NIBBLES - 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t          state_q;
  logic [W-1:0]    a_q;
  logic [W-1:0]    b_q;
  logic [W-1:0]    result_q;
  logic [IW-1:0]   idx_q;
  logic            carry_q;
  logic            cout_q;
  logic            busy_q;
  logic            done_q;

  // The adder sees only latched operands, so a changing a_in/b_in or a
  // start pulse mid-operation cannot disturb the sum in flight.
  always_comb begin
    // NOTE: every output gets a default first so no path infers a latch.
    rca_a   = '0;
    rca_b   = '0;
    rca_cin = 1'b0;
    if (state_q == RUN) begin
      rca_a   = a_q[{idx_q, 2'b00} +: 4];
      rca_b   = b_q[{idx_q, 2'b00} +: 4];
      rca_cin = carry_q;
    end
  end

  // NOTE: all state updates use non-blocking assignments so every register
  // samples values from before the edge, independent of statement order.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= IDLE;
      a_q      <= '0;
      b_q      <= '0;
      result_q <= '0;
      idx_q    <= '0;
      carry_q  <= 1'b0;
      cout_q   <= 1'b0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          if (start) begin
            a_q      <= a_in;
            b_q      <= b_in;
            carry_q  <= cin_in;
            idx_q    <= '0;
            result_q <= '0;
            cout_q   <= 1'b0;
            busy_q   <= 1'b1;
            state_q  <= RUN;
          end
        end
        RUN: begin
          result_q[{idx_q, 2'b00} +: 4] <= rca_sum;
          carry_q <= rca_cout;
          idx_q   <= idx_q + 1'b1;
          if (idx_q == LAST_IDX) begin
            cout_q  <= rca_cout;
            done_q  <= 1'b1;
            state_q <= DONE;
          end
        end
        DONE: begin
          done_q  <= 1'b0;
          busy_q  <= 1'b0;
          state_q <= IDLE;
        end
        default: begin
          done_q  <= 1'b0;
          busy_q  <= 1'b0;
          state_q <= IDLE;
        end
      endcase
    end
  end

  assign busy   = busy_q;
  assign done   = done_q;
  assign result = result_q;
  assign cout   = cout_q;

endmodule

// File: tb/tb_nibble_serial_adder.sv
// Bench for nibble_serial_adder: directed operations go into a scoreboard queue;
// a monitor pops and checks result, carry and latency on every done pulse.
module tb_nibble_serial_adder;

  localparam int NIBBLES = 4;
  localparam int W       = 4 * NIBBLES;

  logic         clk;
  logic         rst;
  logic         start;
  logic [W-1:0] a_in;
  logic [W-1:0] b_in;
  logic         cin_in;
  logic [3:0]   rca_a;
  logic [3:0]   rca_b;
  logic         rca_cin;
  logic [3:0]   rca_sum;
  logic         rca_cout;
  logic         busy;
  logic         done;
  logic [W-1:0] result;
  logic         cout;

  typedef struct {
    logic [W-1:0] res;
    logic         c;
    int           start_cyc;
  } exp_t;

  exp_t sb[$];
  int   checks = 0;
  int   errors = 0;
  int   cyc    = 0;

  nibble_serial_adder #(.NIBBLES(NIBBLES)) dut (
    .clk      (clk),
    .rst      (rst),
    .start    (start),
    .a_in     (a_in),
    .b_in     (b_in),
    .cin_in   (cin_in),
    .rca_a    (rca_a),
    .rca_b    (rca_b),
    .rca_cin  (rca_cin),
    .rca_sum  (rca_sum),
    .rca_cout (rca_cout),
    .busy     (busy),
    .done     (done),
    .result   (result),
    .cout     (cout)
  );

  // External 4-bit ripple-carry adder.
  assign {rca_cout, rca_sum} = {1'b0, rca_a} + {1'b0, rca_b} + {4'b0000, rca_cin};

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [31:0] actual, input logic [31:0] expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, actual, expected, cyc);
    end
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_busy"},    32'(busy),    32'd0);
    check({tag, "_done"},    32'(done),    32'd0);
    check({tag, "_result"},  32'(result),  32'd0);
    check({tag, "_cout"},    32'(cout),    32'd0);
    check({tag, "_rca_a"},   32'(rca_a),   32'd0);
    check({tag, "_rca_b"},   32'(rca_b),   32'd0);
    check({tag, "_rca_cin"}, 32'(rca_cin), 32'd0);
  endtask

  // Monitor: on every done pulse pop the oldest expectation; one cycle later
  // done must have dropped and busy must be low (the single IDLE gap cycle).
  initial begin
    exp_t e;
    bit   post_chk;
    post_chk = 1'b0;
    forever begin
      @(negedge clk);
      if (rst) begin
        post_chk = 1'b0;
      end else begin
        if (post_chk) begin
          check("done_width", 32'(done), 32'd0);
          check("busy_gap",   32'(busy), 32'd0);
          post_chk = 1'b0;
        end
        if (done) begin
          if (sb.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL unexpected_done: got done=1 expected no pending operation (cycle %0d)", cyc);
          end else begin
            e = sb.pop_front();
            check("result",  32'(result),          32'(e.res));
            check("cout",    32'(cout),            32'(e.c));
            check("latency", 32'(cyc - e.start_cyc), 32'd4);
            post_chk = 1'b1;
          end
        end
      end
    end
  end

  task automatic drain(input string tag);
    int n;
    n = 0;
    while (sb.size() != 0 && n < 60) begin
      @(negedge clk);
      n++;
    end
    if (sb.size() != 0) begin
      checks++;
      errors++;
      $display("FAIL %s_timeout: got %0d pending expected 0", tag, sb.size());
      sb.delete();
    end
    repeat (2) @(negedge clk);
  endtask

  // One addition; optionally checks the nibble stream seen by the adder.
  task automatic run_op(input logic [W-1:0] a, input logic [W-1:0] b, input logic ci,
                        input logic [W-1:0] exp_res, input logic exp_c, input bit chk_seq);
    logic [3:0] exp_a [4];
    logic [3:0] exp_b [4];
    exp_a = '{4'h4, 4'h3, 4'h2, 4'h1};
    exp_b = '{4'h8, 4'h7, 4'h6, 4'h5};
    @(negedge clk);
    a_in   = a;
    b_in   = b;
    cin_in = ci;
    start  = 1'b1;
    sb.push_back('{exp_res, exp_c, cyc + 1});
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      if (i == 0) start = 1'b0;
      if (chk_seq) begin
        check($sformatf("rca_a_idx%0d", i), 32'(rca_a), 32'(exp_a[i]));
        check($sformatf("rca_b_idx%0d", i), 32'(rca_b), 32'(exp_b[i]));
        if (i == 0) check("rca_cin_idx0", 32'(rca_cin), 32'(ci));
      end
    end
    @(negedge clk);
    if (chk_seq) begin
      check("rca_a_done", 32'(rca_a),   32'd0);
      check("rca_cin_done", 32'(rca_cin), 32'd0);
    end
    drain("op");
  endtask

  initial begin
    int c0;
    rst    = 1'b1;
    start  = 1'b0;
    a_in   = '0;
    b_in   = '0;
    cin_in = 1'b0;
    repeat (2) @(negedge clk);
    check_all_zero("reset");
    rst = 1'b0;
    @(negedge clk);

    run_op(16'h0001, 16'h0003, 1'b0, 16'h0004, 1'b0, 1'b0);
    check("hold_result_idle", 32'(result), 32'h0004);
    run_op(16'hFFFF, 16'h0001, 1'b0, 16'h0000, 1'b1, 1'b0);
    check("hold_cout_idle", 32'(cout), 32'd1);
    run_op(16'h1234, 16'h5678, 1'b1, 16'h68AD, 1'b0, 1'b1);
    run_op(16'hFFFF, 16'hFFFF, 1'b1, 16'hFFFF, 1'b1, 1'b0);

    // start pulsed mid-RUN with other operands must be ignored.
    @(negedge clk);
    a_in = 16'h0001; b_in = 16'h0003; cin_in = 1'b0; start = 1'b1;
    sb.push_back('{16'h0004, 1'b0, cyc + 1});
    @(negedge clk);
    start = 1'b0;
    a_in = 16'hFFFF; b_in = 16'hFFFF; cin_in = 1'b1;
    @(negedge clk);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    drain("ignore_start");

    // Reset in the second RUN cycle aborts with no done pulse.
    @(negedge clk);
    a_in = 16'h1111; b_in = 16'h2222; cin_in = 1'b1; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    @(negedge clk);
    rst = 1'b1;
    #1;
    check_all_zero("midrun_rst");
    @(negedge clk);
    rst = 1'b0;
    repeat (8) @(negedge clk);
    run_op(16'h0006, 16'h000A, 1'b1, 16'h0011, 1'b0, 1'b0);

    // start held high: accepted every 6 cycles, operands changed between ops.
    @(negedge clk);
    c0 = cyc;
    a_in = 16'h0001; b_in = 16'h0003; cin_in = 1'b0; start = 1'b1;
    sb.push_back('{16'h0004, 1'b0, c0 + 1});
    sb.push_back('{16'h0000, 1'b1, c0 + 7});
    sb.push_back('{16'h68AD, 1'b0, c0 + 13});
    @(negedge clk);
    a_in = 16'hFFFF; b_in = 16'h0001; cin_in = 1'b0;
    repeat (6) @(negedge clk);
    a_in = 16'h1234; b_in = 16'h5678; cin_in = 1'b1;
    repeat (6) @(negedge clk);
    start = 1'b0;
    drain("back_to_back");

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got no completion expected finish before 200000");
    $fatal(1, "watchdog expired");
  end

endmodule
